// File: rtl/accumulator_sequencer.sv
// Sequencing stage around an external 4-bit ripple adder: one handshaked
// operation at a time, with the result captured into a fed-back accumulator.
module accumulator_sequencer #(
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  logic [3:0] din,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] acc,
  output logic       carry,
  output logic       ovf,
  output logic [3:0] adder_a,
  output logic [3:0] adder_b,
  output logic       adder_cin,
  input  logic [3:0] adder_s,
  input  logic       adder_cout
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {OP_CLEAR = 2'b00, OP_LOAD = 2'b01,
                            OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

  state_t     state_q;
  op_t        op_q;
  logic [3:0] din_q;
  logic [3:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       ovf_q, ovf_d;
  logic       in_ready_q;
  logic       out_valid_q;
  logic [3:0] adder_b_q, adder_b_d;
  logic       adder_cin_q, adder_cin_d;

  // Adder operands are set up on the accepting edge so they are stable for all of EXEC.
  always_comb begin
    adder_b_d   = 4'h0;
    adder_cin_d = 1'b0;
    case (op_t'(op))
      OP_ADD: adder_b_d = din;
      OP_SUB: begin
        adder_b_d   = ~din;
        adder_cin_d = 1'b1;
      end
      default: ;
    endcase
  end

  // For SUB the adder carry-out is the inverse of borrow.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (op_q)
      OP_CLEAR: begin
        acc_d   = 4'h0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
      OP_LOAD: begin
        acc_d   = din_q;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
      OP_ADD: begin
        carry_d = adder_cout;
        ovf_d   = ovf_q | adder_cout;
        acc_d   = (SATURATE && adder_cout) ? 4'hF : adder_s;
      end
      OP_SUB: begin
        carry_d = adder_cout;
        ovf_d   = ovf_q | ~adder_cout;
        acc_d   = (SATURATE && !adder_cout) ? 4'h0 : adder_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_CLEAR;
      din_q       <= 4'h0;
      acc_q       <= 4'h0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      adder_b_q   <= 4'h0;
      adder_cin_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q        <= op_t'(op);
            din_q       <= din;
            adder_b_q   <= adder_b_d;
            adder_cin_q <= adder_cin_d;
            in_ready_q  <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          acc_q       <= acc_d;
          carry_q     <= carry_d;
          ovf_q       <= ovf_d;
          adder_b_q   <= 4'h0;
          adder_cin_q <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign adder_a   = acc_q;
  assign adder_b   = adder_b_q;
  assign adder_cin = adder_cin_q;

endmodule
